// File: rtl/uart_rx_cfg_if.sv
// Read-side bundle of the UART receiver: held word, status flags and consumer ack.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 rd_ack;
    logic [DATA_BITS-1:0] dout;
    logic                 valid;
    logic                 done_tick;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        input  rd_ack,
        output dout,
        output valid,
        output done_tick,
        output parity_err,
        output frame_err,
        output overrun
    );

    modport slave (
        output rd_ack,
        input  dout,
        input  valid,
        input  done_tick,
        input  parity_err,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with a compile-time frame format and a one-word holding register.
// Frames with parity or stop-bit errors are still delivered, with their flags alongside.
module uart_rx_cfg #(
    parameter int BITRATE    = 921600,
    parameter int CORE_FREQ  = 100000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic          busy,
    uart_rx_cfg_if.master rd_if
);
    localparam longint DIV_L  = longint'(CORE_FREQ) / (longint'(BITRATE) * longint'(OVERSAMPLE));
    localparam int     DIV    = int'(DIV_L);
    localparam int     TICK_W = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam int     SCNT_W = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] DIV_T     = TICK_W'(DIV);
    localparam logic [SCNT_W-1:0] HALF_M1   = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] FULL_M1   = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
        ((STOP_BITS != 1) && (STOP_BITS != 2)) || (DIV < 1) ||
        (OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_param_check
        $error("uart_rx_cfg: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // mode 2 is even parity, anything else reaching here is odd
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic                 par_bit,
                                             input int                   mode);
        logic even_ref;
        even_ref = ^data;
        if (mode == 2) begin
            return par_bit != even_ref;
        end else begin
            return par_bit != ~even_ref;
        end
    endfunction

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [SCNT_W-1:0]    scnt_q, scnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;

    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 done_q;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q;

    logic                 s_tick;
    logic                 bit_tick_s;
    logic                 frame_done_s;
    logic                 ack_s;

    assign s_tick     = (tick_q == DIV_T);
    assign bit_tick_s = s_tick && (scnt_q == FULL_M1);
    assign ack_s      = rd_if.rd_ack && valid_q;

    // Free-running sample-tick divider: DIV+1 clocks per tick
    always_comb begin
        tick_d = tick_q;
        if (s_tick) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    // Divider register and rx synchronizer with previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= '0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            tick_q    <= tick_d;
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Frame sequencing: next state, sample/bit counters and per-frame capture
    always_comb begin
        state_d      = state_q;
        scnt_d       = scnt_q;
        bcnt_d       = bcnt_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        frame_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // only a falling edge arms reception, so a stuck-low line stays idle
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = ST_START;
                    scnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (s_tick && (scnt_q == HALF_M1)) begin
                    scnt_d = '0;
                    bcnt_d = '0;
                    if (!rx_sync_q) begin
                        state_d = ST_DATA;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (s_tick) begin
                    scnt_d = scnt_q + 1'b1;
                end else begin
                    scnt_d = scnt_q;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    scnt_d  = '0;
                    shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
                    if (bcnt_q == DATA_LAST) begin
                        bcnt_d  = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end else if (s_tick) begin
                    scnt_d = scnt_q + 1'b1;
                end else begin
                    scnt_d = scnt_q;
                end
            end
            ST_PARITY: begin
                if (bit_tick_s) begin
                    scnt_d  = '0;
                    bcnt_d  = '0;
                    perr_d  = parity_mismatch(shreg_q, rx_sync_q, PARITY);
                    state_d = ST_STOP;
                end else if (s_tick) begin
                    scnt_d = scnt_q + 1'b1;
                end else begin
                    scnt_d = scnt_q;
                end
            end
            ST_STOP: begin
                if (bit_tick_s) begin
                    scnt_d = '0;
                    if (!rx_sync_q) begin
                        ferr_d = 1'b1;
                    end else begin
                        ferr_d = ferr_q;
                    end
                    if (bcnt_q == STOP_LAST) begin
                        bcnt_d       = '0;
                        frame_done_s = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end else if (s_tick) begin
                    scnt_d = scnt_q + 1'b1;
                end else begin
                    scnt_d = scnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                scnt_d  = '0;
                bcnt_d  = '0;
            end
        endcase
    end

    // Sequencer state and frame datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Holding register: a completing frame always lands; an ack in the same cycle consumes the old word
    always_comb begin
        dout_d       = dout_q;
        valid_d      = valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        if (frame_done_s) begin
            dout_d       = shreg_q;
            valid_d      = 1'b1;
            parity_err_d = perr_d;
            frame_err_d  = ferr_d;
            if (valid_q && !rd_if.rd_ack) begin
                overrun_d = 1'b1;
            end else if (ack_s) begin
                overrun_d = 1'b0;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (ack_s) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            done_q       <= frame_done_s;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign rd_if.dout       = dout_q;
    assign rd_if.valid      = valid_q;
    assign rd_if.done_tick  = done_q;
    assign rd_if.parity_err = parity_err_q;
    assign rd_if.frame_err  = frame_err_q;
    assign rd_if.overrun    = overrun_q;
    assign busy             = busy_q;
endmodule
